// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back stage GPR file with bypassed read ports, a registered
//            commit record, and cycle/instret counters.
// Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            rfwe_i,
  input  logic [4:0]      rdaddr_i,
  input  logic [XLEN-1:0] rd_wdata_i,
  input  logic [63:0]     inst_addr_i,
  input  logic [31:0]     inst_i,
  input  logic            skip_i,
  input  logic [4:0]      rs1addr_i,
  input  logic [4:0]      rs2addr_i,
  output logic [XLEN-1:0] rs1_rdata_o,
  output logic [XLEN-1:0] rs2_rdata_o,
  output logic            commit_valid_o,
  output logic [63:0]     commit_pc_o,
  output logic [31:0]     commit_inst_o,
  output logic            commit_skip_o,
  output logic            commit_wen_o,
  output logic [4:0]      commit_wdest_o,
  output logic [XLEN-1:0] commit_wdata_o,
  output logic [63:0]     cycle_o,
  output logic [63:0]     instret_o
);

  logic [XLEN-1:0] r_gpr [NREG];
  logic [63:0]     r_cycle;
  logic [63:0]     r_instret;
  logic            w_we;

  // Gating with rst keeps the bypass path quiet while reset is held.
  assign w_we = rst & valid_i & rfwe_i & (rdaddr_i != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_we) begin
      r_gpr[rdaddr_i] <= rd_wdata_i;
    end
  end

  always_comb begin
    rs1_rdata_o = r_gpr[rs1addr_i];
    if (rs1addr_i == 5'd0) begin
      rs1_rdata_o = '0;
    end else if (w_we && (rs1addr_i == rdaddr_i)) begin
      rs1_rdata_o = rd_wdata_i;
    end
  end

  always_comb begin
    rs2_rdata_o = r_gpr[rs2addr_i];
    if (rs2addr_i == 5'd0) begin
      rs2_rdata_o = '0;
    end else if (w_we && (rs2addr_i == rdaddr_i)) begin
      rs2_rdata_o = rd_wdata_i;
    end
  end

  // Commit fields hold their last value across bubbles; only the strobe drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid_o <= 1'b0;
      commit_pc_o    <= '0;
      commit_inst_o  <= '0;
      commit_skip_o  <= 1'b0;
      commit_wen_o   <= 1'b0;
      commit_wdest_o <= '0;
      commit_wdata_o <= '0;
    end else begin
      commit_valid_o <= valid_i;
      if (valid_i) begin
        commit_pc_o    <= inst_addr_i;
        commit_inst_o  <= inst_i;
        commit_skip_o  <= skip_i;
        commit_wen_o   <= w_we;
        commit_wdest_o <= rdaddr_i;
        commit_wdata_o <= rd_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (valid_i) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  assign cycle_o   = r_cycle;
  assign instret_o = r_instret;

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the MEM/WB pipeline register: consumes the registered WB-stage bundle (write enable, destination, data, PC, instruction, skip flag), performs the architectural GPR write, and serves the decode stage's two read ports with same-cycle write bypass. It also produces a registered per-instruction commit record for difftest and maintains the `cycle`/`instret` counters. It sits directly downstream of the MEM/WB register and upstream of decode/difftest.

## Interface
- `XLEN`, 64, GPR and data width
- `NREG`, 32, number of GPRs; index width is 5 bits, x0 hardwired to zero
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  WB slot holds a real instruction (0 for bubble/flushed slot)
- `rfwe_i`  in  1  GPR write enable from MEM/WB
- `rdaddr_i`  in  5  destination register
- `rd_wdata_i`  in  XLEN  write-back data (already selected upstream)
- `inst_addr_i`  in  64  PC of WB instruction
- `inst_i`  in  32  instruction word
- `skip_i`  in  1  difftest skip flag (MMIO etc.)
- `rs1addr_i`, `rs2addr_i`  in  5  decode read addresses
- `rs1_rdata_o`, `rs2_rdata_o`  out  XLEN  combinational read data
- `commit_valid_o`  out  1  registered commit strobe
- `commit_pc_o`  out  64, `commit_inst_o`  out  32, `commit_skip_o`  out  1
- `commit_wen_o`  out  1, `commit_wdest_o`  out  5, `commit_wdata_o`  out  XLEN
- `cycle_o`  out  64  free-running cycle count
- `instret_o`  out  64  retired-instruction count

## Operation
- Effective write `we = valid_i & rfwe_i & (rdaddr_i != 0)`; on rising edge with `we`, `gpr[rdaddr_i] <= rd_wdata_i`. Writes to x0 are discarded; `rfwe_i` with `valid_i=0` is discarded.
- Read port n: if `rsNaddr_i == 0` -> 0; else if `we` and `rsNaddr_i == rdaddr_i` -> `rd_wdata_i` (bypass); else `gpr[rsNaddr_i]`. Both ports independent; same address on both ports returns identical data.
- Commit record: on each edge, `commit_valid_o <= valid_i`; when `valid_i`, capture `inst_addr_i`, `inst_i`, `skip_i`, `we`, `rdaddr_i`, `rd_wdata_i` into the commit fields. When `valid_i=0`, `commit_valid_o` goes 0 and other commit fields hold. `commit_wen_o` reflects `we` (x0 target reports 0).
- `cycle_o` increments by 1 every edge out of reset; `instret_o` increments by 1 on every edge with `valid_i=1` (including skipped instructions). Both wrap 2^64-1 -> 0 silently.
- No stall/flush inputs: MEM/WB already converts stall/flush into `valid_i=0`.

## Timing
- Reset (`rst=0`, async): all GPRs, all commit outputs, `cycle_o`, `instret_o` -> 0 immediately, no clock needed; read outputs therefore 0. Any write in the cycle reset asserts is lost. First increment/write on first rising edge with `rst=1`.
- Read latency 0 (combinational); write visible via array on the edge after `we`, via bypass in the same cycle.
- Commit latency 1: instruction at WB in cycle N appears on commit outputs in cycle N+1 with `instret_o` already including it.
- Back-to-back writes to same register: later one wins; reads in the second cycle see second value via bypass.
- Counter wrap and commit capture are concurrent; no priority conflicts exist (single writer per register).

## Test plan
- Reset: drive random inputs, assert `rst=0` mid-cycle -> all outputs 0 asynchronously; `rs1addr_i=5` reads 0 after release until written.
- Write/read: `valid_i=1,rfwe_i=1,rdaddr_i=3,rd_wdata_i=0xDEAD_BEEF` with `rs1addr_i=3` -> `rs1_rdata_o=0xDEADBEEF` same cycle (bypass) and next cycle (array) after inputs drop.
- x0 and bubble: write 0x1234 to x0 -> reads 0, `commit_wen_o=0`; `valid_i=0,rfwe_i=1,rdaddr_i=7` -> x7 unchanged, `commit_valid_o=0`, `instret_o` unchanged.
- Commit record: PC 0x8000_0000, inst 0x0010_0093, skip 1, write x1=1 -> next cycle commit fields match exactly, `instret_o` +1.
- Back-to-back: x4<=0xA then x4<=0xB consecutive cycles, `rs2addr_i=4` -> 0xA then 0xB, then 0xB held.
- Counters: after 10 cycles with 6 valid instructions post-reset -> `cycle_o=10`, `instret_o=6`; force-preload `instret` to 2^64-1 in sim, one valid -> 0.
